ram_cmd: RTL and testbench

Byte-stream command engine that lets a host (UART receiver/transmitter pair) load and dump the 1024×8 simple dual-port block RAM through its port A. It parses a small burst protocol from the rx byte stream, drives the RAM's port-A enable/write/address/data pins, and returns acknowledges or read data on the tx byte stream. Port B of the RAM stays free for the display/consumer side.

---
 rtl/ram_cmd_pkg.sv | 35 +++
 rtl/ram_cmd_timer.sv | 34 +++
 rtl/ram_cmd.sv | 173 +++++++++++++++++
 tb/tb_ram_cmd.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_cmd_pkg.sv
// Shared constants, state encoding and helpers for the ram_cmd byte-stream
// RAM load/dump engine.
package ram_cmd_pkg;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_HDR_HI  = 4'd1,
    ST_HDR_LO  = 4'd2,
    ST_HDR_CNT = 4'd3,
    ST_WDATA   = 4'd4,
    ST_WR      = 4'd5,
    ST_ACK     = 4'd6,
    ST_NAK     = 4'd7,
    ST_RD_REQ  = 4'd8,
    ST_RD_CAP  = 4'd9,
    ST_RD_SEND = 4'd10
  } state_t;

  // A count byte of zero encodes a full 256-byte burst.
  function automatic logic [8:0] burst_len(input logic [7:0] cnt);
    logic [8:0] len;
    if (cnt == 8'd0) begin
      len = 9'd256;
    end else begin
      len = {1'b0, cnt};
    end
    return len;
  endfunction

endpackage

// File: rtl/ram_cmd_timer.sv
// Inter-byte inactivity counter: clears on demand, counts while enabled and
// saturates at TIMEOUT, where expire stays high until the next clear.
module ram_cmd_timer #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic clock,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_r;

  assign expire = (count_r == LIMIT);

  // Counter register: clear has priority, counting stops at the limit.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && !expire) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/ram_cmd.sv
// Byte-stream command engine: parses W/R burst frames from rx, drives RAM
// port A and answers on tx with ACK/NAK or read data.
module ram_cmd
  import ram_cmd_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              a_en,
  output logic              a_write_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic [7:0]        a_wdata,
  input  logic [7:0]        a_rdata,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state_r, state_s;
  logic [7:0]        hi_r, hi_s;
  logic              is_wr_r, is_wr_s;
  logic [8:0]        remain_r, remain_s;
  logic [ADDR_W-1:0] addr_s;
  logic [7:0]        wdata_s, tx_data_s;
  logic              err_s, tx_valid_s, a_en_s, a_we_s;
  logic              rx_fire_s, tmr_expire_s, tmr_enable_s;
  logic [15:0]       hdr_addr_s;

  assign rx_ready = rst_n && ((state_r == ST_IDLE)   || (state_r == ST_HDR_HI) ||
                              (state_r == ST_HDR_LO) || (state_r == ST_HDR_CNT) ||
                              (state_r == ST_WDATA));
  assign busy         = (state_r != ST_IDLE);
  assign rx_fire_s    = rx_valid && rx_ready;
  assign hdr_addr_s   = {hi_r, rx_data};
  assign tmr_enable_s = rx_ready && (state_r != ST_IDLE);

  ram_cmd_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock  (clock),
    .rst_n  (rst_n),
    .clear  (rx_fire_s || (state_r == ST_IDLE)),
    .enable (tmr_enable_s),
    .expire (tmr_expire_s)
  );

  // Next-state and next-output decode; registered outputs follow state_s.
  always_comb begin
    state_s   = state_r;
    hi_s      = hi_r;
    is_wr_s   = is_wr_r;
    remain_s  = remain_r;
    addr_s    = a_addr;
    wdata_s   = a_wdata;
    tx_data_s = tx_data;
    err_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rx_fire_s) begin
          if (rx_data == OP_WR || rx_data == OP_RD) begin
            is_wr_s = (rx_data == OP_WR);
            state_s = ST_HDR_HI;
          end else begin
            err_s     = 1'b1;
            tx_data_s = RSP_NAK;
            state_s   = ST_NAK;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HDR_HI, ST_HDR_LO, ST_HDR_CNT, ST_WDATA: begin
        if (rx_fire_s) begin
          case (state_r)
            ST_HDR_HI: begin
              hi_s    = rx_data;
              state_s = ST_HDR_LO;
            end
            ST_HDR_LO: begin
              addr_s  = hdr_addr_s[ADDR_W-1:0];
              state_s = ST_HDR_CNT;
            end
            ST_HDR_CNT: begin
              remain_s = burst_len(rx_data);
              state_s  = is_wr_r ? ST_WDATA : ST_RD_REQ;
            end
            default: begin
              wdata_s = rx_data;
              state_s = ST_WR;
            end
          endcase
        end else if (tmr_expire_s) begin
          err_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = state_r;
        end
      end
      ST_WR: begin
        addr_s   = a_addr + ADDR_ONE;
        remain_s = remain_r - 9'd1;
        if (remain_r == 9'd1) begin
          tx_data_s = RSP_ACK;
          state_s   = ST_ACK;
        end else begin
          state_s = ST_WDATA;
        end
      end
      ST_RD_REQ: state_s = ST_RD_CAP;
      ST_RD_CAP: begin
        tx_data_s = a_rdata;
        state_s   = ST_RD_SEND;
      end
      ST_RD_SEND: begin
        if (tx_ready) begin
          addr_s   = a_addr + ADDR_ONE;
          remain_s = remain_r - 9'd1;
          state_s  = (remain_r == 9'd1) ? ST_IDLE : ST_RD_REQ;
        end else begin
          state_s = ST_RD_SEND;
        end
      end
      ST_ACK, ST_NAK: begin
        if (tx_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = ST_IDLE;
    endcase
    tx_valid_s = (state_s == ST_ACK) || (state_s == ST_NAK) || (state_s == ST_RD_SEND);
    a_en_s     = (state_s == ST_WR) || (state_s == ST_RD_REQ);
    a_we_s     = (state_s == ST_WR);
  end

  // State, burst bookkeeping and all registered outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      hi_r       <= 8'd0;
      is_wr_r    <= 1'b0;
      remain_r   <= 9'd0;
      a_addr     <= '0;
      a_wdata    <= 8'd0;
      a_en       <= 1'b0;
      a_write_en <= 1'b0;
      tx_data    <= 8'd0;
      tx_valid   <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_r    <= state_s;
      hi_r       <= hi_s;
      is_wr_r    <= is_wr_s;
      remain_r   <= remain_s;
      a_addr     <= addr_s;
      a_wdata    <= wdata_s;
      a_en       <= a_en_s;
      a_write_en <= a_we_s;
      tx_data    <= tx_data_s;
      tx_valid   <= tx_valid_s;
      err        <= err_s;
    end
  end

endmodule

// File: tb/tb_ram_cmd.sv
// Self-checking bench for ram_cmd: a behavioural RAM on port A, a
// frame-level reference memory model and randomized frames / tx back-pressure.
module tb_ram_cmd;

  localparam int TOUT = 50;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       a_en, a_write_en;
  logic [9:0] a_addr;
  logic [7:0] a_wdata;
  logic [7:0] a_rdata = 8'd0;
  logic       busy, err;

  ram_cmd #(.ADDR_W(10), .TIMEOUT(TOUT)) dut (
    .clock(clock), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .a_en(a_en), .a_write_en(a_write_en), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rdata(a_rdata),
    .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] ram [1024];
  logic [7:0] ref_mem [1024];
  logic [7:0] got_q[$];
  int wr_cycles = 0, err_cnt = 0, stall_events = 0, stall_bad = 0;
  logic stalled = 1'b0;
  logic [7:0] stall_data = 8'd0;
  bit rdy_rand = 1'b0;
  bit rdy_force = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Port-A RAM: read-first, data valid the cycle after an enabled cycle.
  always @(posedge clock) begin
    if (a_en) begin
      if (a_write_en) ram[a_addr] <= a_wdata;
      a_rdata <= ram[a_addr];
    end
  end

  // tx capture, stall-stability bookkeeping and event counters.
  always @(posedge clock) begin
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    if (stalled && tx_valid) begin
      stall_events <= stall_events + 1;
      if (tx_data !== stall_data) stall_bad <= stall_bad + 1;
    end
    stalled    <= tx_valid && !tx_ready;
    stall_data <= tx_data;
    if (a_en && a_write_en) wr_cycles <= wr_cycles + 1;
    if (err) err_cnt <= err_cnt + 1;
  end

  initial begin
    forever begin
      @(negedge clock);
      tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk("rx_accept", {31'd0, rx_ready}, 32'd1);
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int need);
    int n = 0;
    while ((got_q.size() < need || busy) && n < 20000) begin
      @(negedge clock);
      n++;
    end
  endtask

  // Sends one frame and checks the tx stream against the reference memory.
  task automatic run_frame(input logic [7:0] op, input logic [15:0] hdr,
                           input logic [7:0] cnt, input string tag);
    logic [7:0] exp_q[$];
    logic [9:0] a;
    logic [7:0] d;
    int n, w0;
    n = (cnt == 8'd0) ? 256 : int'(cnt);
    a = hdr[9:0];
    got_q.delete();
    w0 = wr_cycles;
    send_byte(op);
    if (op == 8'h57 || op == 8'h52) begin
      send_byte(hdr[15:8]);
      send_byte(hdr[7:0]);
      send_byte(cnt);
      for (int i = 0; i < n; i++) begin
        if (op == 8'h57) begin
          d = 8'($urandom);
          ref_mem[a] = d;
          send_byte(d);
        end else begin
          exp_q.push_back(ref_mem[a]);
        end
        a = a + 10'd1;
      end
      if (op == 8'h57) exp_q.push_back(8'h06);
    end else begin
      exp_q.push_back(8'h15);
    end
    wait_idle(exp_q.size());
    @(negedge clock);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    chk({tag, "_wrcyc"}, wr_cycles - w0, (op == 8'h57) ? n : 0);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_tx%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    logic [7:0] op;
    int e0, waited, mism;

    // Reset values while rst_n is held low.
    rx_valid = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_a_en", a_en, 0);
    chk("rst_a_we", a_write_en, 0);
    chk("rst_a_addr", a_addr, 0);
    chk("rst_a_wdata", a_wdata, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    rx_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clock);
    chk("idle_rx_ready", rx_ready, 1);

    // Fill the whole RAM with CNT=0 bursts so the model is fully known.
    for (int k = 0; k < 4; k++) run_frame(8'h57, 16'(k * 256), 8'h00, "fill");

    // Directed 3-byte write.
    got_q.delete();
    e0 = wr_cycles;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    wait_idle(1);
    @(negedge clock);
    ref_mem[10'h010] = 8'hAA; ref_mem[10'h011] = 8'hBB; ref_mem[10'h012] = 8'hCC;
    chk("w3_wrcyc", wr_cycles - e0, 3);
    chk("w3_ack_len", got_q.size(), 1);
    if (got_q.size() > 0) chk("w3_ack", got_q[0], 8'h06);
    chk("w3_ram0", ram[10'h010], 8'hAA);
    chk("w3_ram1", ram[10'h011], 8'hBB);
    chk("w3_ram2", ram[10'h012], 8'hCC);

    // Seed across the top of RAM, then read back with address wrap.
    got_q.delete();
    send_byte(8'h57); send_byte(8'h03); send_byte(8'hFF); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22);
    wait_idle(1);
    ref_mem[10'h3FF] = 8'h11; ref_mem[10'h000] = 8'h22;
    chk("wrap_ram_hi", ram[10'h3FF], 8'h11);
    chk("wrap_ram_lo", ram[10'h000], 8'h22);
    run_frame(8'h52, 16'h03FF, 8'h02, "rwrap");
    run_frame(8'h52, 16'hFC10, 8'h03, "rhibits");

    // Bad opcode: err pulse + NAK, then a normal write.
    e0 = err_cnt;
    run_frame(8'h41, 16'h0000, 8'h00, "nak");
    chk("nak_err", err_cnt - e0, 1);
    run_frame(8'h57, 16'h0123, 8'h04, "after_nak");

    // Timeout after the first data byte of a 2-byte write.
    got_q.delete();
    e0 = err_cnt;
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h5A);
    ref_mem[10'h100] = 8'h5A;
    waited = 0;
    while (err_cnt == e0 && waited < TOUT + 40) begin
      @(negedge clock);
      waited++;
    end
    chk("tout_err", err_cnt - e0, 1);
    chk("tout_not_early", waited >= TOUT, 1);
    chk("tout_not_late", waited <= TOUT + 6, 1);
    chk("tout_busy", busy, 0);
    repeat (3) @(negedge clock);
    chk("tout_no_tx", got_q.size(), 0);
    chk("tout_ram", ram[10'h100], 8'h5A);
    chk("tout_ram_next", ram[10'h101], ref_mem[10'h101]);

    // 256-byte read under random back-pressure.
    rdy_rand = 1'b1;
    run_frame(8'h52, 16'h0280, 8'h00, "r256");

    // Random mix of frames.
    for (int k = 0; k < 20; k++) begin
      case ($urandom_range(0, 9))
        0: begin
          op = 8'($urandom);
          if (op == 8'h57 || op == 8'h52) op = 8'h41;
        end
        1, 2, 3, 4: op = 8'h57;
        default: op = 8'h52;
      endcase
      run_frame(op, 16'($urandom), ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 12)), "rnd");
    end

    // Reset during a stalled read burst.
    rdy_rand = 1'b0;
    rdy_force = 1'b0;
    @(negedge clock);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h20); send_byte(8'h0A);
    waited = 0;
    while (!tx_valid && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    chk("mid_tx_valid_pre", tx_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_tx_valid", tx_valid, 0);
    chk("mid_a_en", a_en, 0);
    chk("mid_busy", busy, 0);
    chk("mid_tx_data", tx_data, 0);
    @(negedge clock);
    rst_n = 1'b1;
    rdy_force = 1'b1;
    repeat (3) @(negedge clock);
    chk("post_rst_tx_valid", tx_valid, 0);
    got_q.delete();
    run_frame(8'h57, 16'h0020, 8'h05, "post_rst_w");
    run_frame(8'h52, 16'h001E, 8'h08, "post_rst_r");

    // Whole-memory consistency and tx stall stability.
    mism = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) mism++;
    chk("mem_final", mism, 0);
    chk("stall_seen", stall_events > 0, 1);
    chk("stall_stable", stall_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
